// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU feeding the EX/MEM register and the Z/V/N flags, with stall and flush.
// Optional macro EX_SAT_ADD_EN: ADD/SUB overflow saturates to 0x7FFF/0x8000 instead of wrapping.

module paddsb (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic [4:0] laneSum [4];

    // A 5-bit lane sum overflows exactly when its top two bits disagree
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < 4; i++) begin
            laneSum[i] = {a_i[4*i+3], a_i[4*i +: 4]} + {b_i[4*i+3], b_i[4*i +: 4]};
            if (laneSum[i][4] != laneSum[i][3])
                sum_o[4*i +: 4] = laneSum[i][4] ? 4'h8 : 4'h7;
            else
                sum_o[4*i +: 4] = laneSum[i][3:0];
        end
    end
endmodule

module ex_alu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  dst,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_result,
    output logic [3:0]  out_dst,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n
);
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    logic [15:0] bOp;
    logic [15:0] addSum;
    logic [15:0] addRes;
    logic        addOvf;
    logic [7:0]  redSum;
    logic [15:0] paddRes;
    logic [15:0] aluRes_d;
    logic        isAddSub;
    logic        accept;

    logic        valid_q;
    logic [15:0] result_q;
    logic [3:0]  dst_q;
    logic        flagZ_q;
    logic        flagV_q;
    logic        flagN_q;

    paddsb uPaddsb (
        .a_i   (a),
        .b_i   (b),
        .sum_o (paddRes)
    );

    // Shared adder: SUB is a + ~b + 1, overflow judged on the inverted operand
    always_comb begin
        bOp    = (op == OP_SUB) ? ~b : b;
        addSum = a + bOp + {15'd0, (op == OP_SUB)};
        addOvf = (a[15] == bOp[15]) && (addSum[15] != a[15]);
`ifdef EX_SAT_ADD_EN
        addRes = addOvf ? (a[15] ? 16'h8000 : 16'h7FFF) : addSum;
`else
        addRes = addSum;
`endif
    end

    always_comb begin
        redSum = '0;
        for (int i = 0; i < 4; i++) begin
            redSum = redSum + {{4{a[4*i+3]}}, a[4*i +: 4]} + {{4{b[4*i+3]}}, b[4*i +: 4]};
        end
    end

    always_comb begin
        aluRes_d = '0;
        case (op)
            OP_ADD, OP_SUB: aluRes_d = addRes;
            OP_XOR:         aluRes_d = a ^ b;
            OP_RED:         aluRes_d = {{8{redSum[7]}}, redSum};
            OP_SLL:         aluRes_d = a << b[3:0];
            OP_SRA:         aluRes_d = $signed(a) >>> b[3:0];
            OP_ROR:         aluRes_d = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
            OP_PADDSB:      aluRes_d = paddRes;
            default:        aluRes_d = '0;
        endcase
    end

    assign isAddSub = (op == OP_ADD) || (op == OP_SUB);
    assign accept   = in_valid && !stall && !flush && !op[3];

    // EX/MEM register: reset beats flush, flush beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= '0;
            flagZ_q  <= 1'b0;
            flagV_q  <= 1'b0;
            flagN_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= accept;
            if (accept) begin
                result_q <= aluRes_d;
                dst_q    <= dst;
                flagZ_q  <= (aluRes_d == 16'h0000);
                if (isAddSub) begin
                    flagV_q <= addOvf;
                    flagN_q <= aluRes_d[15];
                end
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign flag_z     = flagZ_q;
    assign flag_v     = flagV_q;
    assign flag_n     = flagN_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: randomized scoreboard bench for ex_alu_stage against an arithmetic reference model.
// Honours EX_SAT_ADD_EN the same way the design does.

module tb_ex_alu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dst;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    typedef struct {
        logic        valid;
        logic [15:0] res;
        logic [3:0]  dst;
        logic        z;
        logic        v;
        logic        n;
        bit          chkData;
    } exp_t;

    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;

    logic        mValid = 1'b0;
    logic [15:0] mRes   = '0;
    logic [3:0]  mDst   = '0;
    logic        mZ     = 1'b0;
    logic        mV     = 1'b0;
    logic        mN     = 1'b0;
    bit          mAfterReset = 1'b0;

    ex_alu_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .dst        (dst),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_dst    (out_dst),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n)
    );

    always #5 clk = ~clk;

    // Reference ALU written from the arithmetic meaning of each opcode
    function automatic void refAlu(input logic [3:0] rop, input logic [15:0] ra, input logic [15:0] rb,
                                   output logic [15:0] res, output logic ovf);
        int sa, sb, s, amt, na, nb, lane;
        logic [15:0] r;
        sa  = int'($signed(ra));
        sb  = int'($signed(rb));
        amt = int'(rb[3:0]);
        ovf = 1'b0;
        res = '0;
        case (rop)
            4'd0, 4'd1: begin
                s   = (rop == 4'd0) ? sa + sb : sa - sb;
                ovf = (s > 32767) || (s < -32768);
`ifdef EX_SAT_ADD_EN
                if (s > 32767)       res = 16'h7FFF;
                else if (s < -32768) res = 16'h8000;
                else                 res = s[15:0];
`else
                res = s[15:0];
`endif
            end
            4'd2: res = ra ^ rb;
            4'd3: begin
                s = 0;
                for (int i = 0; i < 4; i++) begin
                    na = (ra >> (4 * i)) & 15;
                    nb = (rb >> (4 * i)) & 15;
                    s  = s + (na > 7 ? na - 16 : na) + (nb > 7 ? nb - 16 : nb);
                end
                res = s[15:0];
            end
            4'd4: begin
                s   = (int'(ra) << amt) & 32'hFFFF;
                res = s[15:0];
            end
            4'd5: begin
                s   = sa >>> amt;
                res = s[15:0];
            end
            4'd6: begin
                r = ra;
                for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
                res = r;
            end
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    na   = (ra >> (4 * i)) & 15;
                    nb   = (rb >> (4 * i)) & 15;
                    lane = (na > 7 ? na - 16 : na) + (nb > 7 ? nb - 16 : nb);
                    if (lane > 7)  lane = 7;
                    if (lane < -8) lane = -8;
                    res[4*i +: 4] = lane[3:0];
                end
            end
            default: res = '0;
        endcase
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the expected post-edge state
    task automatic applyStimulus(input logic iRst, input logic iValid, input logic [3:0] iOp,
                                 input logic [15:0] iA, input logic [15:0] iB, input logic [3:0] iDst,
                                 input logic iStall, input logic iFlush);
        logic [15:0] res;
        logic        ovf;
        exp_t        e;
        @(negedge clk);
        rst = iRst; in_valid = iValid; op = iOp; a = iA; b = iB; dst = iDst;
        stall = iStall; flush = iFlush;
        if (iRst) begin
            mValid = 0; mRes = 0; mDst = 0; mZ = 0; mV = 0; mN = 0;
            mAfterReset = 1'b1;
        end else if (iFlush) begin
            mValid = 0;
        end else if (!iStall) begin
            mValid = iValid && !iOp[3];
            if (mValid) begin
                refAlu(iOp, iA, iB, res, ovf);
                mRes = res;
                mDst = iDst;
                mZ   = (res == 16'h0000);
                if (iOp <= 4'd1) begin
                    mV = ovf;
                    mN = res[15];
                end
                mAfterReset = 1'b0;
            end
        end
        e.valid = mValid; e.res = mRes; e.dst = mDst;
        e.z = mZ; e.v = mV; e.n = mN;
        e.chkData = mValid || mAfterReset;
        sbQueue.push_back(e);
    endtask

    task automatic compareBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareWord(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareBit("out_valid", out_valid, e.valid);
        compareBit("flag_z", flag_z, e.z);
        compareBit("flag_v", flag_v, e.v);
        compareBit("flag_n", flag_n, e.n);
        if (e.chkData) begin
            compareWord("out_result", out_result, e.res);
            compareWord("out_dst", {12'd0, out_dst}, {12'd0, e.dst});
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after it
    always @(posedge clk) begin
        #1;
        if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end

    task automatic directWord(input string name, input logic [15:0] exp);
        @(posedge clk);
        #2;
        compareWord(name, out_result, exp);
    endtask

    initial begin
        rst = 1; in_valid = 0; op = 0; a = 0; b = 0; dst = 0; stall = 0; flush = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 16'h1111, 16'h2222, 4'd1, 0, 0);

        applyStimulus(0, 1, 4'd0, 16'h7FFF, 16'h0001, 4'd3, 0, 0);
`ifdef EX_SAT_ADD_EN
        directWord("add_sat", 16'h7FFF);
`else
        directWord("add_wrap", 16'h8000);
`endif
        applyStimulus(0, 1, 4'd1, 16'h1234, 16'h1234, 4'd4, 0, 0);
        directWord("sub_zero", 16'h0000);
        applyStimulus(0, 1, 4'd7, 16'h7181, 16'h11F1, 4'd5, 0, 0);
        directWord("paddsb", 16'h7282);
        applyStimulus(0, 1, 4'd3, 16'h7777, 16'h7777, 4'd6, 0, 0);
        directWord("red", 16'h0038);
        applyStimulus(0, 1, 4'd5, 16'h8000, 16'h000F, 4'd7, 0, 0);
        directWord("sra", 16'hFFFF);
        applyStimulus(0, 1, 4'd6, 16'h0001, 16'h0001, 4'd8, 0, 0);
        directWord("ror", 16'h8000);
        applyStimulus(0, 1, 4'd4, 16'hABCD, 16'h0010, 4'd9, 0, 0);
        directWord("sll_zero_amt", 16'hABCD);

        applyStimulus(0, 1, 4'd2, 16'hF0F0, 16'h0FF0, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 4'd0, 16'h0005, 16'h0006, 4'd10, 1, 0);
        applyStimulus(0, 1, 4'd0, 16'h0005, 16'h0006, 4'd10, 0, 0);

        applyStimulus(0, 1, 4'd0, 16'h0001, 16'hFFFF, 4'd11, 0, 1);
        applyStimulus(0, 1, 4'd0, 16'h0001, 16'hFFFF, 4'd11, 1, 1);
        applyStimulus(0, 1, 4'd1, 16'h0003, 16'h0003, 4'd12, 0, 0);
        applyStimulus(0, 1, 4'd2, 16'h1234, 16'h4321, 4'd13, 0, 0);
        applyStimulus(1, 1, 4'd0, 16'h4000, 16'h4000, 4'd14, 0, 0);
        applyStimulus(0, 1, 4'd9, 16'h0001, 16'h0001, 4'd15, 0, 0);
        applyStimulus(0, 1, 4'd1, 16'h8000, 16'h0001, 4'd1, 0, 0);
        applyStimulus(0, 1, 4'd9, 16'h0000, 16'h0000, 4'd2, 0, 0);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rop;
            int          pick;
            pick = $urandom_range(0, 9);
            ra = (pick == 0) ? 16'h7FFF : (pick == 1) ? 16'h8000 : 16'($urandom);
            pick = $urandom_range(0, 9);
            rb = (pick == 0) ? 16'h0001 : (pick == 1) ? 16'hFFFF : (pick == 2) ? ra : 16'($urandom);
            rop = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), rop, ra, rb,
                          4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0));
        end

        for (int i = 0; i < 20 && sbQueue.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
